// File: rtl/lane_deskew_auto.sv
// Lane-to-lane deskew for the 128b/130b RX path: times each lane's alignment
// marker, derives per-lane delays and re-aligns data, count, sync and valid.
module lane_deskew_auto #(
    parameter int LANES    = 4,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 4,
    parameter int MAX_SKEW = 7,
    parameter int SEL_W    = $clog2(MAX_SKEW + 1)
) (
    input  logic                    RX_CLK,
    input  logic                    rst,
    input  logic                    Soft_RST_blocks,
    input  logic                    EN_LTSSM,
    input  logic                    GEN,
    input  logic                    deskew_req,
    input  logic [LANES*DATA_W-1:0] rx_data,
    input  logic [LANES*CNT_W-1:0]  rx_count,
    input  logic [LANES-1:0]        rx_sync,
    input  logic [LANES-1:0]        rx_valid,
    input  logic [LANES-1:0]        rx_marker,
    output logic [LANES*DATA_W-1:0] dsk_data,
    output logic [LANES*CNT_W-1:0]  dsk_count,
    output logic [LANES-1:0]        dsk_sync,
    output logic [LANES-1:0]        dsk_valid,
    output logic [LANES*SEL_W-1:0]  lane_delay,
    output logic                    deskew_done,
    output logic                    deskew_error
);
    localparam int W = DATA_W + CNT_W + 2;
    localparam logic [SEL_W-1:0] SKEW_MAX = SEL_W'(MAX_SKEW);

    typedef enum logic [1:0] {IDLE, SEARCH, ALIGNED, ERROR} state_t;

    state_t           state, state_nxt;
    logic             en;
    logic             start, complete, timeout;
    logic             age_run;
    logic [SEL_W-1:0] age, age_now, t_max;
    logic [LANES-1:0] seen, seen_nxt;
    logic [SEL_W-1:0] arrival [LANES];
    logic [SEL_W-1:0] dly     [LANES];

    assign en       = EN_LTSSM && GEN;
    // The age counter only runs once the first marker of a measurement shows up.
    assign age_now  = age_run ? age : '0;
    assign seen_nxt = seen | rx_marker;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the edge, independent of block order.
    always_ff @(posedge RX_CLK or negedge rst) begin
        if (!rst)                 state <= IDLE;
        else if (Soft_RST_blocks) state <= IDLE;
        else                      state <= state_nxt;
    end

    // NOTE: every signal of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ALIGNED, ERROR: begin
                    if (deskew_req) begin
                        state_nxt = SEARCH;
                        start     = 1'b1;
                    end
                end
                SEARCH: begin
                    if (deskew_req) begin
                        start = 1'b1;
                    end else if (&seen) begin
                        state_nxt = ALIGNED;
                        complete  = 1'b1;
                    end else if (age_run && age_now == SKEW_MAX && !(&seen_nxt)) begin
                        state_nxt = ERROR;
                        timeout   = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        t_max = '0;
        for (int i = 0; i < LANES; i++) begin
            if (arrival[i] > t_max) t_max = arrival[i];
        end
    end

    always_ff @(posedge RX_CLK or negedge rst) begin
        if (!rst) begin
            age_run      <= 1'b0;
            age          <= '0;
            seen         <= '0;
            deskew_done  <= 1'b0;
            deskew_error <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                arrival[i] <= '0;
                dly[i]     <= '0;
            end
        end else if (Soft_RST_blocks) begin
            age_run      <= 1'b0;
            age          <= '0;
            seen         <= '0;
            deskew_done  <= 1'b0;
            deskew_error <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                arrival[i] <= '0;
                dly[i]     <= '0;
            end
        end else if (!en) begin
            deskew_done  <= 1'b0;
            deskew_error <= 1'b0;
        end else if (start) begin
            age_run      <= 1'b0;
            age          <= '0;
            seen         <= '0;
            deskew_done  <= 1'b0;
            deskew_error <= 1'b0;
        end else if (complete) begin
            deskew_done <= 1'b1;
            for (int i = 0; i < LANES; i++) dly[i] <= t_max - arrival[i];
        end else if (timeout) begin
            deskew_error <= 1'b1;
        end else if (state == SEARCH) begin
            if (age_run || (|rx_marker)) begin
                age_run <= 1'b1;
                age     <= (age_now == SKEW_MAX) ? SKEW_MAX : age_now + 1'b1;
            end
            // Only the first marker per lane counts; simultaneous markers share age_now.
            for (int i = 0; i < LANES; i++) begin
                if (rx_marker[i] && !seen[i]) begin
                    seen[i]    <= 1'b1;
                    arrival[i] <= age_now;
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W-1:0] in_word, out_word;
        logic [W-1:0] line [MAX_SKEW];

        assign in_word = {rx_data[g*DATA_W +: DATA_W], rx_count[g*CNT_W +: CNT_W],
                          rx_sync[g], rx_valid[g]};

        // NOTE: the delay line is a memory that is nonetheless reset, so no stale
        // symbol from before a reset can reach the outputs through a tap.
        always_ff @(posedge RX_CLK or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < MAX_SKEW; k++) line[k] <= '0;
            end else if (Soft_RST_blocks) begin
                for (int k = 0; k < MAX_SKEW; k++) line[k] <= '0;
            end else if (en) begin
                line[0] <= in_word;
                for (int k = 1; k < MAX_SKEW; k++) line[k] <= line[k-1];
            end
        end

        // Tap k is the input k cycles ago; tap 0 is the live input.
        always_comb begin
            out_word = in_word;
            if (en) begin
                for (int k = 1; k <= MAX_SKEW; k++) begin
                    if (dly[g] == SEL_W'(k)) out_word = line[k-1];
                end
            end
        end

        assign dsk_data[g*DATA_W +: DATA_W]  = out_word[W-1 -: DATA_W];
        assign dsk_count[g*CNT_W +: CNT_W]   = out_word[2 +: CNT_W];
        assign dsk_sync[g]                   = out_word[1];
        assign dsk_valid[g]                  = out_word[0];
        assign lane_delay[g*SEL_W +: SEL_W]  = dly[g];
    end

endmodule

// File: doc/lane_deskew_auto.md
# lane_deskew_auto

Multi-lane, parametrised lane-to-lane deskew for the Gen3+ (128b/130b) RX path, placed after the per-lane elastic buffers and before the byte un-striping logic. It measures inter-lane skew from a per-lane alignment-marker pulse and computes each lane's delay itself. It then delays every lane's data, symbol count, sync header and valid so that all lanes leave the block aligned. It reports completion, skew overflow and the chosen per-lane delays to the LTSSM.

## Interface
- LANES, 4: number of lanes
- DATA_W, 8: symbol width per lane
- CNT_W, 4: symbol-count width per lane
- MAX_SKEW, 7: largest compensable skew in RX_CLK cycles; also the delay-line depth
- SEL_W, $clog2(MAX_SKEW+1): per-lane delay-select width

- RX_CLK  in  1  receive clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Soft_RST_blocks  in  1  synchronous clear, active-high, same effect as rst
- EN_LTSSM  in  1  block enable from LTSSM
- GEN  in  1  1 = 128b/130b mode, 0 = bypass
- deskew_req  in  1  single-cycle pulse that starts a skew measurement
- rx_data  in  LANES*DATA_W  skewed symbols, lane i at [i*DATA_W +: DATA_W]
- rx_count  in  LANES*CNT_W  per-lane symbol count
- rx_sync  in  LANES  per-lane block type (sync header)
- rx_valid  in  LANES  per-lane valid
- rx_marker  in  LANES  per-lane pulse on the first symbol of the alignment ordered set
- dsk_data, dsk_count, dsk_sync, dsk_valid  out  same widths as inputs  deskewed outputs
- lane_delay  out  LANES*SEL_W  applied delay per lane
- deskew_done  out  1  alignment achieved, level
- deskew_error  out  1  skew exceeded MAX_SKEW, level

## Operation
- Each lane has a MAX_SKEW-deep shift register carrying {data, count, sync, valid}.
  - The register shifts every cycle while EN_LTSSM && GEN, regardless of rx_valid. It holds otherwise.
  - Tap k is the input delayed k cycles. Tap 0 is a combinational pass-through.
- Output lane i = tap lane_delay[i] when EN_LTSSM && GEN. Otherwise the output is the undelayed input.
- State machine states: IDLE, SEARCH, ALIGNED, ERROR.
  - IDLE --deskew_req--> SEARCH.
  - SEARCH, all lanes seen --> ALIGNED.
  - SEARCH, timeout --> ERROR.
  - ALIGNED or ERROR --deskew_req--> SEARCH.
  - Any state, !(EN_LTSSM && GEN) --> IDLE. lane_delay is retained; deskew_done and deskew_error are cleared.
- SEARCH measurement:
  - The age counter starts at 0 on the first cycle with any rx_marker bit set.
  - A lane's arrival time t_i is the age value in the cycle its marker is first seen.
  - Repeat markers on a lane already seen are ignored.
  - Markers in the same cycle share one t.
- Completion: when every lane has been seen, T_max = max t_i and lane_delay[i] = T_max - t_i. The latest lane gets 0; the earliest gets T_max.
- Timeout: if the cycle with age == MAX_SKEW ends with any lane unseen, go to ERROR.
  - deskew_error = 1.
  - lane_delay keeps its previous values.
- Entering SEARCH clears deskew_done, deskew_error and the seen flags. lane_delay stays unchanged until completion.
- Arithmetic: t_i and age are SEL_W bits wide. age saturates at MAX_SKEW and never wraps.

## Timing
- Reset values (rst low or Soft_RST_blocks high):
  - State IDLE; all delay registers, lane_delay, age and seen flags 0; deskew_done = 0, deskew_error = 0.
  - dsk_* follow the inputs combinationally.
- deskew_req is sampled only when EN_LTSSM && GEN. A deskew_req during SEARCH restarts the measurement.
- The last marker is seen at edge n. At edge n+1, lane_delay is updated, deskew_done rises and the state becomes ALIGNED.
  - The outputs switch taps at that same edge, n+1.
- Alignment guarantee: a symbol entering lane i at cycle c_i appears on dsk_* at cycle c_i + lane_delay[i]. For the marker symbol this is the same cycle on every lane.
- Reset is accepted mid-SEARCH and aborts the measurement. Outputs revert to tap 0 immediately (rst) or at the next edge (Soft_RST_blocks).

## Test plan
- LANES=4, MAX_SKEW=7. Markers at relative cycles 0,2,5,1 on lanes 0..3 -> lane_delay = 5,3,0,4. deskew_done rises 1 cycle after the lane-2 marker. Marker symbols exit on the same cycle on all lanes.
- All four markers in the same cycle -> lane_delay all 0, deskew_done = 1 next cycle, outputs equal inputs.
- Lane 3 marker arrives at age 8 or never -> deskew_error = 1 one cycle after age 7, state ERROR, lane_delay unchanged from the previous result.
- Skew exactly 7 (lane 0 at age 0, the others at age 7) -> lane_delay[0] = 7, no error.
- GEN=0 mid-SEARCH -> state IDLE, outputs bypass. A subsequent deskew_req with GEN=1 completes normally.
- rst pulse while ALIGNED with non-zero delays -> all flags 0, lane_delay 0, dsk_data = rx_data in the same cycle.
